// File: rtl/clock_gate_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } cg_state_e;

  localparam int CG_WAKE_LAT_DEF   = 2;
  localparam int CG_IDLE_CNT_W_DEF = 8;

endpackage

// File: rtl/clock_gate_ctrl.sv
// Drives clock_gate.clk_en from downstream activity: idle hysteresis before gating,
// a fixed WAKE run-in before RUN, and a four-phase ack toward the wake requester.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int IDLE_CNT_W = CG_IDLE_CNT_W_DEF,
  parameter int WAKE_LAT   = CG_WAKE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busy,
  input  logic                  wake_req,
  output logic                  wake_ack,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  force_on,
  output logic                  clk_en,
  output logic                  gated
);

  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_OFF  = OFF;
  localparam logic [1:0] ST_WAKE = WAKE;

  localparam int WAKE_CNT_W = $clog2(WAKE_LAT + 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_LAT);
  localparam logic [WAKE_CNT_W-1:0] WAKE_ONE  = WAKE_CNT_W'(1);

  logic [1:0]            state_reg, state_next;
  logic [IDLE_CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [WAKE_CNT_W-1:0] wake_cnt_reg, wake_cnt_next;
  logic                  clk_en_reg, gated_reg, wake_ack_reg;

  logic                  idle_cycle;
  logic                  wake_event;
  logic [IDLE_CNT_W:0]   idle_cnt_inc;
  logic                  thresh_hit;
  logic                  idle_cnt_sat;

  // A pending request counts as activity, so an open handshake can never gate the clock.
  assign idle_cycle   = !busy && !wake_req && !force_on && (idle_thresh != '0);
  assign wake_event   = wake_req || busy || force_on;
  assign idle_cnt_inc = {1'b0, idle_cnt_reg} + {{IDLE_CNT_W{1'b0}}, 1'b1};
  assign thresh_hit   = idle_cnt_inc >= {1'b0, idle_thresh};
  assign idle_cnt_sat = &idle_cnt_reg;

  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    wake_cnt_next = wake_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (!idle_cycle) begin
          idle_cnt_next = '0;
        end else if (thresh_hit) begin
          state_next    = ST_OFF;
          idle_cnt_next = '0;
        end else if (!idle_cnt_sat) begin
          idle_cnt_next = idle_cnt_inc[IDLE_CNT_W-1:0];
        end
      end
      ST_OFF: begin
        if (wake_event) begin
          state_next    = ST_WAKE;
          wake_cnt_next = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // Run-in is unconditional: the requester only sees ack once the clock has settled.
        if (wake_cnt_reg <= WAKE_ONE) begin
          state_next    = ST_RUN;
          wake_cnt_next = '0;
        end else begin
          wake_cnt_next = wake_cnt_reg - WAKE_ONE;
        end
      end
      default: begin
        state_next    = ST_RUN;
        idle_cnt_next = '0;
        wake_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      idle_cnt_reg <= '0;
      wake_cnt_reg <= '0;
      clk_en_reg   <= 1'b1;
      gated_reg    <= 1'b0;
      wake_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      wake_cnt_reg <= wake_cnt_next;
      clk_en_reg   <= (state_next != ST_OFF);
      gated_reg    <= (state_next == ST_OFF);
      wake_ack_reg <= (state_next == ST_RUN) && wake_req;
    end
  end

  assign clk_en   = clk_en_reg;
  assign gated    = gated_reg;
  assign wake_ack = wake_ack_reg;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with default parameters (IDLE_CNT_W=8, WAKE_LAT=2).
module tb_clock_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       wake_req;
  logic       wake_ack;
  logic [7:0] idle_thresh;
  logic       force_on;
  logic       clk_en;
  logic       gated;

  int tests;
  int fails;

  clock_gate_ctrl #(.IDLE_CNT_W(8), .WAKE_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .wake_req    (wake_req),
    .wake_ack    (wake_ack),
    .idle_thresh (idle_thresh),
    .force_on    (force_on),
    .clk_en      (clk_en),
    .gated       (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One line per checkpoint; gated is always checked as the complement of clk_en.
  task automatic chk_out(input string tag, input logic exp_en, input logic exp_ack);
    chk({tag, ".clk_en"}, clk_en, exp_en);
    chk({tag, ".gated"}, gated, !exp_en);
    chk({tag, ".wake_ack"}, wake_ack, exp_ack);
    $display("[TB] %s clk_en=%b gated=%b wake_ack=%b", tag, clk_en, gated, wake_ack);
  endtask

  logic saw_off;

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    busy        = 1'b1;
    wake_req    = 1'b0;
    force_on    = 1'b0;
    idle_thresh = 8'd4;

    // Reset state
    step();
    step();
    chk_out("reset", 1'b1, 1'b0);

    // Gating after 4 idle edges
    rst  = 1'b0;
    busy = 1'b0;
    step(); chk_out("idle_e1", 1'b1, 1'b0);
    step(); chk_out("idle_e2", 1'b1, 1'b0);
    step(); chk_out("idle_e3", 1'b1, 1'b0);
    step(); chk_out("idle_e4_off", 1'b0, 1'b0);

    // Wake handshake from OFF
    wake_req = 1'b1;
    step(); chk_out("wake_w0", 1'b1, 1'b0);
    step(); chk_out("wake_w1", 1'b1, 1'b0);
    step(); chk_out("wake_w2_ack", 1'b1, 1'b1);
    step(); chk_out("wake_hold_ack", 1'b1, 1'b1);
    wake_req = 1'b0;
    step(); chk_out("ack_release", 1'b1, 1'b0);
    step(); chk_out("regate_e2", 1'b1, 1'b0);
    step(); chk_out("regate_e3", 1'b1, 1'b0);
    step(); chk_out("regate_e4_off", 1'b0, 1'b0);

    // busy wakes without handshake
    busy = 1'b1;
    step(); chk_out("busy_wake_w0", 1'b1, 1'b0);
    busy = 1'b0;
    step(); chk_out("busy_wake_w1", 1'b1, 1'b0);
    step(); chk_out("busy_wake_run", 1'b1, 1'b0);

    // idle_thresh=0 never gates
    idle_thresh = 8'd0;
    saw_off = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!clk_en) saw_off = 1'b1;
    end
    chk("thresh0_300.never_off", saw_off, 1'b0);
    $display("[TB] thresh0_300 saw_off=%b", saw_off);

    // force_on never gates
    idle_thresh = 8'd4;
    force_on = 1'b1;
    saw_off = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!clk_en) saw_off = 1'b1;
    end
    chk("force_on_300.never_off", saw_off, 1'b0);
    $display("[TB] force_on_300 saw_off=%b", saw_off);

    force_on = 1'b0;
    step(); step(); step();
    chk_out("force_drop_e3", 1'b1, 1'b0);
    step(); chk_out("force_drop_e4_off", 1'b0, 1'b0);

    // force_on wakes from OFF, no ack
    force_on = 1'b1;
    step(); chk_out("force_wake_w0", 1'b1, 1'b0);
    step(); chk_out("force_wake_w1", 1'b1, 1'b0);
    step(); chk_out("force_wake_run", 1'b1, 1'b0);
    force_on = 1'b0;

    // Threshold edge coincides with wake_req rising
    idle_thresh = 8'd3;
    busy = 1'b1;
    step();
    busy = 1'b0;
    step(); chk_out("coinc_e1", 1'b1, 1'b0);
    step(); chk_out("coinc_e2", 1'b1, 1'b0);
    wake_req = 1'b1;
    step(); chk_out("coinc_e3_run_ack", 1'b1, 1'b1);
    wake_req = 1'b0;
    step(); chk_out("coinc_release", 1'b1, 1'b0);
    step(); chk_out("coinc_idle2", 1'b1, 1'b0);
    step(); chk_out("coinc_idle3_off", 1'b0, 1'b0);

    // Lower threshold mid-count
    busy = 1'b1;
    step(); step(); step();
    chk_out("thr_lower_wake_run", 1'b1, 1'b0);
    busy = 1'b0;
    idle_thresh = 8'd10;
    for (int i = 0; i < 5; i++) step();
    chk_out("thr_lower_5idle", 1'b1, 1'b0);
    idle_thresh = 8'd2;
    step(); chk_out("thr_lower_off", 1'b0, 1'b0);

    // Async reset while in WAKE with wake_cnt=1
    idle_thresh = 8'd4;
    wake_req = 1'b1;
    step(); chk_out("rst_wake_w0", 1'b1, 1'b0);
    step(); chk_out("rst_wake_w1", 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    wake_req = 1'b0;
    #1;
    chk_out("rst_in_wake", 1'b1, 1'b0);
    step();
    rst = 1'b0;
    step(); chk_out("post_rst_e1", 1'b1, 1'b0);
    step(); step();
    chk_out("post_rst_e3", 1'b1, 1'b0);
    step(); chk_out("post_rst_e4_off", 1'b0, 1'b0);

    // Async reset while in OFF ungates immediately
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_in_off", 1'b1, 1'b0);
    step();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Generates the `clk_en` input for a `clock_gate` cell from downstream activity, with idle hysteresis and a four-phase wake handshake toward the requester. It runs on the ungated clock, in the same domain as the `clock_gate` it drives. It sits beside each gated router/DSU sub-block. It guarantees the gated clock has been running for `WAKE_LAT` cycles before it acknowledges a wake request.

## Interface
Parameters:
- `IDLE_CNT_W`, 8: width of the idle counter and of `idle_thresh`.
- `WAKE_LAT`, 2: number of cycles the clock runs in WAKE before RUN. Legal range is at least 1.

Ports:
- `clk`, input, 1: ungated free-running clock.
- `rst`, input, 1: reset; asynchronous, active-high.
- `busy`, input, 1: activity from the gated logic. High means the block is not idle.
- `wake_req`, input, 1: four-phase wake request. It is held high until `wake_ack` is seen.
- `wake_ack`, output, 1: wake acknowledge.
- `idle_thresh`, input, IDLE_CNT_W: number of consecutive idle cycles before gating. A value of 0 means never gate.
- `force_on`, input, 1: override that keeps the clock running.
- `clk_en`, output, 1: registered enable to `clock_gate.clk_en`.
- `gated`, output, 1: status. High while in OFF.

## Operation
- States:
  - RUN: `clk_en`=1.
  - OFF: `clk_en`=0.
  - WAKE: `clk_en`=1.
- All outputs are registered.
- Idle condition per cycle: `!busy && !wake_req && !force_on && idle_thresh!=0`.
- RUN:
  - `idle_cnt` increments on each idle cycle and saturates at all-ones.
  - `idle_cnt` clears on any non-idle cycle.
  - On an idle cycle where `idle_cnt+1 >= idle_thresh`, go to OFF and clear `idle_cnt`.
  - Because the test is `>=`, lowering `idle_thresh` mid-count takes effect on the next idle edge.
- OFF:
  - Any of `wake_req`, `busy` or `force_on` → WAKE, and load `wake_cnt=WAKE_LAT`.
  - `busy` wakes the clock without producing a handshake.
- WAKE:
  - `wake_cnt` decrements every cycle. When it reaches 1 → RUN.
  - Inputs are ignored; WAKE cannot be aborted.
- `wake_ack` update: registered as `wake_ack <= (next_state==RUN) && wake_req`.
  - It therefore stays high while `wake_req` is high in RUN.
  - It falls on the edge that samples `wake_req` low.
- While `wake_req` or `wake_ack` is high, the block never enters OFF, because `wake_req` counts as activity.
- Simultaneous events:
  - If the threshold is reached on the same edge that `wake_req` rises, the block stays in RUN.
  - If `busy` and `wake_req` both rise while in OFF, there is one WAKE pass followed by the ack.
- Reset, including mid-operation: state → RUN immediately. `clk_en`=1, `wake_ack`=0, `gated`=0, and both counters = 0.

## Timing
- Gating latency: `busy` is sampled low on edges e1..eN with N=`idle_thresh`. `clk_en` and `gated` change after eN (`clk_en` falls, `gated` rises).
- Wake latency from OFF: `wake_req` is sampled high at edge w0, after which `clk_en`=1. `wake_ack`=1 after edge w(WAKE_LAT).
- Wake latency in RUN: `wake_ack`=1 after the first edge that samples `wake_req` high.
- Ack release: `wake_ack`=0 after the edge that samples `wake_req` low.
- `gated` equals `!clk_en` at all times.

## Structure
- `clock_gate_pkg` holds:
  - `cg_state_e`, an enum {RUN, OFF, WAKE}, 2 bits;
  - `CG_WAKE_LAT_DEF`=2;
  - `CG_IDLE_CNT_W_DEF`=8.
- No sub-module. The block is a single FSM with two counters.
- Top-level integration pairs each `clock_gate_ctrl.clk_en` with one `clock_gate` instance.

## Test plan
- Reset then idle, `idle_thresh`=4, `busy`=0 → `clk_en` falls and `gated` rises after the 4th edge.
- In OFF with `WAKE_LAT`=2, assert `wake_req` → `clk_en`=1 after w0 and `wake_ack`=1 after w2. Drop `wake_req` → `wake_ack`=0 after the next edge. After 4 further idle edges, OFF again.
- `idle_thresh`=0 or `force_on`=1, with `busy`=0 for 300 cycles → `clk_en` stays 1. Raising `force_on` while in OFF → WAKE, then RUN after 2 cycles, with no `wake_ack`.
- `idle_thresh`=3 with `wake_req` rising on the 3rd idle edge → stays in RUN and `wake_ack`=1 after that edge. Change `idle_thresh` from 10 to 2 after 5 idle cycles → OFF after the next idle edge.
- Assert `rst` while in WAKE with `wake_cnt`=1 → immediately `clk_en`=1, `wake_ack`=0, `gated`=0. After release, behaviour matches RUN from reset.
